// File: rtl/stream_downsizer_counter.sv
// Generic up-counter cell: synchronous clear has priority over increment.
module counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         count_o <= '0;
      else if (clr_i)
         count_o <= '0;
      else if (en_i)
         count_o <= count_o + 1'b1;
   end

endmodule

// File: rtl/stream_downsizer.sv
// Splits a RATIO*DATA_W word into 1..RATIO narrow beats, LSB first.
// Outputs are registered; ready_o is combinational so reloads have no bubble.
module stream_downsizer #(
   parameter int DATA_W = 8,
   parameter int RATIO  = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clr_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [RATIO*DATA_W-1:0]   data_i,
   input  logic [((RATIO > 2) ? $clog2(RATIO) : 1)-1:0] nbeats_i,
   input  logic                      last_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [DATA_W-1:0]         data_o,
   output logic                      last_o
);

   localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                  state;
   logic [RATIO*DATA_W-1:0] word_q;
   logic [CNT_W-1:0]        nbeats_q;
   logic                    last_q;
   logic [CNT_W-1:0]        idx;
   logic [CNT_W-1:0]        idx_nxt;
   logic [CNT_W-1:0]        nbeats_clamp;
   logic [DATA_W-1:0]       beat_nxt;
   logic                    out_hs;
   logic                    final_beat;
   logic                    in_hs;

   assign out_hs     = valid_o & ready_i;
   assign final_beat = (idx == nbeats_q);
   assign ready_o    = ~rst_i & ~clr_i & ((state == IDLE) | (out_hs & final_beat));
   assign in_hs      = valid_i & ready_o;
   assign idx_nxt    = idx + 1'b1;

   // Out-of-range beat counts only arise for non-power-of-2 RATIO.
   always_comb begin
      nbeats_clamp = nbeats_i;
      if (nbeats_i > CNT_W'(RATIO - 1))
         nbeats_clamp = CNT_W'(RATIO - 1);
   end

   always_comb begin
      beat_nxt = '0;
      for (int k = 0; k < RATIO; k++)
         if (idx_nxt == CNT_W'(k))
            beat_nxt = word_q[k*DATA_W +: DATA_W];
   end

   counter #(.WIDTH(CNT_W)) u_idx (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clr_i | in_hs),
      .en_i    (out_hs & ~final_beat & ~clr_i),
      .count_o (idx)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         word_q   <= '0;
         nbeats_q <= '0;
         last_q   <= 1'b0;
         valid_o  <= 1'b0;
         data_o   <= '0;
         last_o   <= 1'b0;
      end else if (clr_i) begin
         state   <= IDLE;
         valid_o <= 1'b0;
         last_o  <= 1'b0;
      end else if (in_hs) begin
         state    <= SEND;
         word_q   <= data_i;
         nbeats_q <= nbeats_clamp;
         last_q   <= last_i;
         valid_o  <= 1'b1;
         data_o   <= data_i[DATA_W-1:0];
         last_o   <= last_i & (nbeats_clamp == '0);
      end else if (out_hs) begin
         if (final_beat) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
         end else begin
            data_o <= beat_nxt;
            last_o <= last_q & (idx_nxt == nbeats_q);
         end
      end
   end

endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer: directed plus random steps against a beat-queue model.
module tb_stream_downsizer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        clr_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_i;
   logic [1:0]  nbeats_i;
   logic        last_i;
   logic        valid_o;
   logic        ready_i;
   logic [7:0]  data_o;
   logic        last_o;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   beat_t q[$];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk_i = ~clk_i;

   stream_downsizer #(.DATA_W(8), .RATIO(4)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (clr_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .nbeats_i (nbeats_i),
      .last_i   (last_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .data_o   (data_o),
      .last_o   (last_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, check, advance model to the next posedge.
   task automatic step(input logic v, input logic [31:0] d, input logic [1:0] nb,
                       input logic l, input logic r, input logic c);
      logic exp_rdy, in_hs, out_hs;
      valid_i = v; data_i = d; nbeats_i = nb; last_i = l; ready_i = r; clr_i = c;
      #1;
      exp_rdy = !rst_i && !c && (q.size() == 0 || (q.size() == 1 && r));
      chk("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
      chk("valid_o", {31'd0, valid_o}, {31'd0, q.size() != 0});
      if (rst_i) begin
         chk("rst_data_o", {24'd0, data_o}, 32'd0);
         chk("rst_last_o", {31'd0, last_o}, 32'd0);
      end else if (q.size() != 0) begin
         chk("data_o", {24'd0, data_o}, {24'd0, q[0].d});
         chk("last_o", {31'd0, last_o}, {31'd0, q[0].l});
      end
      in_hs  = v && exp_rdy;
      out_hs = (q.size() != 0) && r;
      if (rst_i || c) q.delete();
      else begin
         if (out_hs) void'(q.pop_front());
         if (in_hs)
            for (int k = 0; k <= int'(nb); k++)
               q.push_back('{d: d[k*8 +: 8], l: l && (k == int'(nb))});
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 32'h0, 2'd0, 0, 1, 0);
   endtask

   initial begin
      rst_i = 1'b1; clr_i = 0; valid_i = 0; data_i = 0; nbeats_i = 0; last_i = 0; ready_i = 1;
      @(negedge clk_i);
      // reset held with valid_i asserted: nothing accepted
      for (int i = 0; i < 3; i++) step(1, 32'h12345678, 2'd3, 1, 1, 0);
      rst_i = 1'b0;
      idle(1);

      // full word
      step(1, 32'hDDCCBBAA, 2'd3, 1, 1, 0);
      idle(5);
      // partial word
      step(1, 32'h44332211, 2'd1, 0, 1, 0);
      idle(3);
      // back-to-back, valid held until the second word is taken
      step(1, 32'h03020100, 2'd3, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 32'h07060504, 2'd3, 0, 1, 0);
      idle(5);
      // backpressure while BB is shown
      step(1, 32'hDDCCBBAA, 2'd3, 1, 1, 0);
      idle(1);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 2'd0, 0, 0, 0);
      idle(4);
      // clear while BB is shown, then a fresh word
      step(1, 32'hDDCCBBAA, 2'd3, 1, 1, 0);
      idle(1);
      step(1, 32'h99999999, 2'd3, 1, 1, 1);
      step(1, 32'h0000BEEF, 2'd1, 0, 1, 0);
      idle(3);

      // asynchronous reset mid-word
      step(1, 32'hCAFEF00D, 2'd3, 1, 1, 0);
      idle(1);
      #1 rst_i = 1'b1;
      #1;
      q.delete();
      chk("async_rst_valid_o", {31'd0, valid_o}, 32'd0);
      chk("async_rst_ready_o", {31'd0, ready_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      idle(3);

      // random traffic
      for (int i = 0; i < 2000; i++)
         step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 31) == 0));
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
